// File: rtl/ascon_pkg.sv
// Shared ASCON controller definitions: operation codes, FSM state encoding, default round counts.
// Mode 101 (HASH) is a legal operation only when ASCON_HASH_EN is defined.
package ascon_pkg;
   localparam int ROUNDS_A_DEF = 12;
   localparam int ROUNDS_B_DEF = 6;

   typedef enum logic [2:0] {
      MODE_NOP     = 3'b000,
      MODE_INIT    = 3'b001,
      MODE_ABSORB  = 3'b010,
      MODE_ENCRYPT = 3'b011,
      MODE_FINAL   = 3'b100,
      MODE_HASH    = 3'b101
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ROUND = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // No-op counts as legal: it is silently ignored rather than flagged.
   function automatic logic mode_is_legal(input logic [2:0] m);
`ifdef ASCON_HASH_EN
      return m <= MODE_HASH;
`else
      return m <= MODE_FINAL;
`endif
   endfunction
endpackage

// File: rtl/ascon_op_controller_if.sv
// Request/strobe bundle between the SPI register file (master) and the op controller (slave).
interface ascon_op_controller_if;
   logic [2:0] operation_mode;
   logic       operation_ready;
   logic       ld_init;
   logic       xor_data;
   logic       xor_key_pre;
   logic       xor_key_post;
   logic       round_en;
   logic [3:0] round_idx;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output operation_mode, operation_ready,
      input  ld_init, xor_data, xor_key_pre, xor_key_post, round_en, round_idx, busy, done, err
   );
   modport slave (
      input  operation_mode, operation_ready,
      output ld_init, xor_data, xor_key_pre, xor_key_post, round_en, round_idx, busy, done, err
   );
endinterface

// File: rtl/ascon_ready_sync.sv
// Two-flop synchronizer for the SCK-domain request level plus rising-edge detect.
module ascon_ready_sync (
   input  logic clk,
   input  logic spi_rst_n,
   input  logic level,
   output logic rise
);
   logic ready_p0, ready_p1, ready_p2;

   always_ff @(posedge clk or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         ready_p0 <= 1'b0;
         ready_p1 <= 1'b0;
         ready_p2 <= 1'b0;
      end else begin
         ready_p0 <= level;
         ready_p1 <= ready_p0;
         ready_p2 <= ready_p1;
      end
   end

   assign rise = ready_p1 & ~ready_p2;
endmodule

// File: rtl/ascon_op_controller.sv
// ASCON operation sequencer: IDLE -> PRE -> ROUND x N -> POST -> DONE, driving permutation-core strobes.
// Define ASCON_HASH_EN to accept mode 101 (HASH); otherwise it is rejected as undefined.
module ascon_op_controller
   import ascon_pkg::*;
#(
   parameter int ROUNDS_A = ROUNDS_A_DEF,
   parameter int ROUNDS_B = ROUNDS_B_DEF
) (
   input logic                  clk,
   input logic                  spi_rst_n,
   ascon_op_controller_if.slave bus
);
   localparam logic [3:0] N_A = 4'(ROUNDS_A);
   localparam logic [3:0] N_B = 4'(ROUNDS_B);

   state_e     state_q, state_d;
   logic [2:0] mode_q;
   logic [3:0] rnd_cnt_q;
   logic [3:0] n_rounds;
   logic       err_q, trig, start;
   logic       ld_init_c, xor_data_c, xor_key_pre_c, xor_key_post_c, round_en_c, busy_c, done_c;
   logic [3:0] round_idx_c;

   ascon_ready_sync u_sync (
      .clk       (clk),
      .spi_rst_n (spi_rst_n),
      .level     (bus.operation_ready),
      .rise      (trig)
   );

   assign start    = trig && (state_q == ST_IDLE) && mode_is_legal(bus.operation_mode)
                     && (bus.operation_mode != MODE_NOP);
   assign n_rounds = (mode_q == MODE_ABSORB || mode_q == MODE_ENCRYPT) ? N_B : N_A;

   always_ff @(posedge clk or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= '0;
         rnd_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) mode_q <= bus.operation_mode;
         if (state_q == ST_ROUND) rnd_cnt_q <= rnd_cnt_q + 4'd1;
         else                     rnd_cnt_q <= '0;
         // A trigger that cannot be honoured (busy or undefined code) is sticky until reset.
         if (trig && (state_q != ST_IDLE || !mode_is_legal(bus.operation_mode))) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      ld_init_c      = 1'b0;
      xor_data_c     = 1'b0;
      xor_key_pre_c  = 1'b0;
      xor_key_post_c = 1'b0;
      round_en_c     = 1'b0;
      round_idx_c    = '0;
      busy_c         = 1'b0;
      done_c         = 1'b0;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_PRE;
         ST_PRE: begin
            busy_c  = 1'b1;
            state_d = ST_ROUND;
            case (mode_q)
               MODE_INIT, MODE_HASH:     ld_init_c = 1'b1;
               MODE_ABSORB, MODE_ENCRYPT: xor_data_c = 1'b1;
               MODE_FINAL: begin
                  xor_data_c    = 1'b1;
                  xor_key_pre_c = 1'b1;
               end
               default: ;
            endcase
         end
         ST_ROUND: begin
            busy_c      = 1'b1;
            round_en_c  = 1'b1;
            round_idx_c = 4'd12 - n_rounds + rnd_cnt_q;
            if (rnd_cnt_q == n_rounds - 4'd1) state_d = ST_POST;
         end
         ST_POST: begin
            busy_c         = 1'b1;
            xor_key_post_c = (mode_q == MODE_INIT) || (mode_q == MODE_FINAL);
            state_d        = ST_DONE;
         end
         ST_DONE: begin
            busy_c  = 1'b1;
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.ld_init      = ld_init_c;
   assign bus.xor_data     = xor_data_c;
   assign bus.xor_key_pre  = xor_key_pre_c;
   assign bus.xor_key_post = xor_key_post_c;
   assign bus.round_en     = round_en_c;
   assign bus.round_idx    = round_idx_c;
   assign bus.busy         = busy_c;
   assign bus.done         = done_c;
   assign bus.err          = err_q;
endmodule

// File: doc/ascon_op_controller.md
ASCON_OP_CONTROLLER -- requirements
Module: ascon_op_controller

Interface
REQ-001 SHALL have parameter ROUNDS_A, default 12, initialization/finalization permutation round count.
REQ-002 SHALL have parameter ROUNDS_B, default 6, data-block permutation round count (legal 1..12).
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port spi_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port operation_mode, input, 3, requested operation code from the SPI register file.
REQ-006 SHALL have port operation_ready, input, 1, request strobe from the SCK domain (level).
REQ-007 SHALL have port ld_init, output, 1, one-cycle pulse: load IV||K||N into state S_0..S_4.
REQ-008 SHALL have port xor_data, output, 1, one-cycle pulse: XOR data block into S_0.
REQ-009 SHALL have port xor_key_pre, output, 1, one-cycle pulse: XOR key into S_1/S_2 before finalization rounds.
REQ-010 SHALL have port xor_key_post, output, 1, one-cycle pulse: XOR key into S_3/S_4 after rounds.
REQ-011 SHALL have port round_en, output, 1, permutation core executes one round this cycle.
REQ-012 SHALL have port round_idx, output, 4, round-constant index for the current round.
REQ-013 SHALL have ports busy (1), done (1) and err (1), outputs: operation active, one-cycle completion pulse, sticky error.

Function
REQ-014 SHALL pass operation_ready through a two-flop synchronizer and treat a rising edge of the synchronized level as a trigger.
REQ-015 SHALL latch operation_mode in the trigger cycle; later mode changes SHALL NOT affect the running operation.
REQ-016 SHALL decode modes: 001 INIT, 010 ABSORB, 011 ENCRYPT, 100 FINAL; 000 no-op, with no outputs and no error.
REQ-017 SHALL sequence FSM states IDLE -> PRE (1 cycle) -> ROUND (N cycles) -> POST (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-018 SHALL assert in PRE: ld_init for INIT, xor_data for ABSORB/ENCRYPT, xor_data and xor_key_pre together for FINAL.
REQ-019 SHALL use N=ROUNDS_A for INIT/FINAL and N=ROUNDS_B for ABSORB/ENCRYPT; round_en=1 for exactly N cycles.
REQ-020 SHALL drive round_idx from 12-N up to 11, incrementing by one per ROUND cycle; round_idx=0 outside ROUND.
REQ-021 SHALL assert xor_key_post in POST for INIT and FINAL only.
REQ-022 SHALL pulse done in DONE; busy SHALL be 1 from PRE through DONE inclusive.
REQ-023 SHALL give total latency from trigger to done of N+3 cycles.
REQ-024 SHALL ignore a trigger arriving while busy=1 and SHALL set err.
REQ-025 SHALL set err on an undefined mode (101-111), stay in IDLE, and produce no pulses.
REQ-026 SHALL clear err only on reset.
REQ-027 SHALL never assert more than one of ld_init/round_en/xor_key_post in the same cycle.

Reset
REQ-028 SHALL, while spi_rst_n=0, immediately force FSM to IDLE, clear the synchronizer, round counter and latched mode, and drive every output to 0.
REQ-029 SHALL abort any in-progress operation on reset with no done pulse; the first trigger after release SHALL start cleanly.

Configuration
REQ-030 SHALL decode mode 101 as HASH (PRE: ld_init with hash IV, N=ROUNDS_A, no key XOR in POST) when macro ASCON_HASH_EN is defined.
REQ-031 SHALL treat mode 101 as undefined (REQ-025) when ASCON_HASH_EN is undefined.

Structure
REQ-032 SHALL take mode codes, FSM state encodings and default round counts from the shared package ascon_pkg.
REQ-033 SHALL implement REQ-014 in sub-module ascon_ready_sync (2-FF sync plus rising-edge detect).

Verification
REQ-034 SHALL cover: mode 001 plus trigger -> ld_init at T+1, round_en for 12 cycles with round_idx 0..11, xor_key_post, then done at T+15.
REQ-035 SHALL cover: mode 011 -> xor_data pulse, round_idx 6..11, no key pulses, done at T+9.
REQ-036 SHALL cover: mode 100 -> xor_data and xor_key_pre in the same cycle, 12 rounds, xor_key_post, done.
REQ-037 SHALL cover: second trigger during ROUND -> err=1, running operation completes unchanged, exactly one done.
REQ-038 SHALL cover: mode 110 trigger -> err=1, busy stays 0; mode 000 trigger -> no activity, err unchanged.
REQ-039 SHALL cover: spi_rst_n low mid-ROUND -> all outputs 0 asynchronously, no done; a new INIT after release completes normally.
